// File: rtl/finalsoc_sample_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : finalsoc_sample_fifo_if
// Description : Avalon-MM slave bus plus sample output stream and interrupt
//               line for the audio sample FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface finalsoc_sample_fifo_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        irq;

  // CPU/bench side: drives the bus and the downstream ready
  modport master (
    output address, chipselect, write_n, writedata, sample_ready,
    input  readdata, sample_data, sample_valid, irq
  );

  // FIFO side
  modport slave (
    input  address, chipselect, write_n, writedata, sample_ready,
    output readdata, sample_data, sample_valid, irq
  );
endinterface
`default_nettype wire

// File: rtl/finalsoc_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : finalsoc_sample_fifo
// Description : CPU-filled 16-bit PCM sample FIFO, drained at a programmable
//               sample rate onto a valid/ready stream, with low-watermark irq.
// Revision    : 1.0 - initial release
// ============================================================================
module finalsoc_sample_fifo #(
  parameter int          DEPTH        = 64,
  parameter int          ADDR_W       = 6,
  parameter logic [15:0] DIV_RESET    = 16'h0411,
  parameter logic [15:0] THRESH_RESET = 16'h0010
) (
  input  logic                  clk,
  input  logic                  reset_n,
  finalsoc_sample_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] C_DEPTH = DEPTH[ADDR_W:0];

  logic [15:0]       mem [DEPTH];

  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic [15:0]       divider_q, divider_d;
  logic [15:0]       thresh_q, thresh_d;
  logic [15:0]       div_cnt_q, div_cnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]       sample_data_q, sample_data_d;
  logic              sample_valid_q, sample_valid_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;
  logic              irq_pending_q, irq_pending_d;
  logic              lowflag_dly_q, lowflag_dly_d;
  logic [15:0]       readdata_q, readdata_d;

  logic wr_status, wr_ctrl, wr_div, wr_thresh, wr_data;
  logic full, empty, tick, stall, pop, push, flush, lowflag;
  logic [15:0] head;

  assign head = mem[rd_ptr_q];

  // Bus decode and FIFO/divider event qualification
  always_comb begin
    wr_status = 1'b0;
    wr_ctrl   = 1'b0;
    wr_div    = 1'b0;
    wr_thresh = 1'b0;
    wr_data   = 1'b0;
    if (bus.chipselect && !bus.write_n) begin
      wr_status = (bus.address == 3'd0);
      wr_ctrl   = (bus.address == 3'd1);
      wr_div    = (bus.address == 3'd2);
      wr_thresh = (bus.address == 3'd3);
      wr_data   = (bus.address == 3'd5);
    end
    full    = (count_q == C_DEPTH);
    empty   = (count_q == '0);
    // A DIVIDER write suppresses the tick while the counter reloads
    tick    = enable_q && (div_cnt_q == 16'd0) && !wr_div;
    stall   = sample_valid_q && !bus.sample_ready;
    pop     = tick && !stall && !empty;
    // Fullness is judged before any same-cycle pop
    push    = wr_data && !full;
    flush   = wr_ctrl && bus.writedata[2];
    lowflag = enable_q && ({{(15 - ADDR_W){1'b0}}, count_q} <= thresh_q);
  end

  // Control registers and sample-period counter
  always_comb begin
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    divider_d = divider_q;
    thresh_d  = thresh_q;
    div_cnt_d = div_cnt_q;
    if (wr_ctrl) begin
      enable_d = bus.writedata[0];
      irq_en_d = bus.writedata[1];
    end
    if (wr_div)    divider_d = bus.writedata;
    if (wr_thresh) thresh_d  = bus.writedata;
    if (!enable_q)              div_cnt_d = divider_q;
    else if (wr_div)            div_cnt_d = bus.writedata;
    else if (div_cnt_q == 16'd0) div_cnt_d = divider_q;
    else                        div_cnt_d = div_cnt_q - 16'd1;
  end

  // FIFO pointers and fill count; flush overrides push and pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Output sample register: load on tick unless the held sample is stalled
  always_comb begin
    sample_data_d  = sample_data_q;
    sample_valid_d = sample_valid_q;
    if (tick && !stall) begin
      sample_valid_d = 1'b1;
      sample_data_d  = empty ? 16'h0000 : head;
    end else if (sample_valid_q && bus.sample_ready) begin
      sample_valid_d = 1'b0;
    end
  end

  // Sticky status flags; a STATUS write wins over a same-cycle set
  always_comb begin
    underrun_d    = underrun_q;
    overflow_d    = overflow_q;
    irq_pending_d = irq_pending_q;
    lowflag_dly_d = lowflag;
    if (tick && !stall && empty)    underrun_d    = 1'b1;
    if (wr_data && full)            overflow_d    = 1'b1;
    if (lowflag && !lowflag_dly_q)  irq_pending_d = 1'b1;
    if (wr_status) begin
      underrun_d    = 1'b0;
      overflow_d    = 1'b0;
      irq_pending_d = 1'b0;
    end
  end

  // Read mux, registered every cycle for one-cycle read latency
  always_comb begin
    readdata_d = 16'h0000;
    case (bus.address)
      3'd0: readdata_d = {11'd0, overflow_q, underrun_q, empty, full, irq_pending_q};
      3'd1: readdata_d = {14'd0, irq_en_q, enable_q};
      3'd2: readdata_d = divider_q;
      3'd3: readdata_d = thresh_q;
      3'd4: readdata_d = {{(15 - ADDR_W){1'b0}}, count_q};
      default: readdata_d = 16'h0000;
    endcase
  end

  // Sample storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= bus.writedata;
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q       <= 1'b0;
      irq_en_q       <= 1'b0;
      divider_q      <= DIV_RESET;
      thresh_q       <= THRESH_RESET;
      div_cnt_q      <= DIV_RESET;
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      sample_data_q  <= 16'h0000;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      overflow_q     <= 1'b0;
      irq_pending_q  <= 1'b0;
      lowflag_dly_q  <= 1'b0;
      readdata_q     <= 16'h0000;
    end else begin
      enable_q       <= enable_d;
      irq_en_q       <= irq_en_d;
      divider_q      <= divider_d;
      thresh_q       <= thresh_d;
      div_cnt_q      <= div_cnt_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
      overflow_q     <= overflow_d;
      irq_pending_q  <= irq_pending_d;
      lowflag_dly_q  <= lowflag_dly_d;
      readdata_q     <= readdata_d;
    end
  end

  assign bus.readdata     = readdata_q;
  assign bus.sample_data  = sample_data_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.irq          = irq_pending_q && irq_en_q;

endmodule
`default_nettype wire

// File: doc/finalsoc_sample_fifo.md
Name: finalsoc_sample_fifo

Overview:
Avalon-MM slave audio sample buffer for the SoC. The CPU, paced by the interval timer interrupt, writes 16-bit PCM samples into an internal FIFO. A programmable sample-rate divider pops one sample per sample period and presents it on a valid/ready stream to the downstream codec/DAC stage. A low-watermark interrupt requests refills.

Parameters:
DEPTH, 64, FIFO depth in samples (power of two)
ADDR_W, 6, log2(DEPTH); the fill counter is ADDR_W+1 bits
DIV_RESET, 16'h0411, divider reset value (1041; 50 MHz / 1042 ≈ 48 kHz)
THRESH_RESET, 16'h0010, low-watermark reset value

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock; reset is asynchronous and active-low
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
sample_data  out  16  current output sample
sample_valid  out  1  sample_data valid
sample_ready  in  1  downstream accepts sample when high with sample_valid
irq  out  1  interrupt request, level

Behaviour:
- wr = chipselect && ~write_n && (address == N). readdata <= mux(address) every cycle, so read latency is 1. Unmapped addresses read 0.
- Register map:
  - 0 STATUS: bit0 irq_pending, bit1 full, bit2 empty, bit3 underrun, bit4 overflow. Any write clears bits 0, 3 and 4.
  - 1 CONTROL: bit0 enable, bit1 irq_enable. Writing bit2=1 flushes the FIFO; bit2 is a strobe and is not stored.
  - 2 DIVIDER: 16-bit period register.
  - 3 THRESHOLD: low-watermark level.
  - 4 FILL: reads {0, count}, read-only.
  - 5 DATA: a write pushes writedata. Reads return 0.
- Reset state: all outputs 0, FIFO empty, CONTROL 0, DIVIDER=DIV_RESET, THRESHOLD=THRESH_RESET, div counter=DIV_RESET. Reset mid-stream discards all contents immediately.
- FIFO: circular buffer with rd_ptr, wr_ptr and count; full = (count==DEPTH), empty = (count==0). Pointers wrap from DEPTH-1 to 0.
- Push on a DATA write:
  - Full is evaluated before any pop in the same cycle. If full, the write is dropped and overflow is set.
  - Push and pop in the same cycle: both take effect and count is unchanged.
  - Flush clears pointers and count. Flush beats a simultaneous push and pop.
- Divider:
  - While enable=0, the counter holds the DIVIDER value and no ticks occur.
  - While enable=1, the counter decrements each cycle. At 0 it asserts tick for one cycle and reloads DIVIDER, so the tick period is DIVIDER+1 cycles.
  - A DIVIDER write forces a reload on the next cycle with no tick. DIVIDER=0 gives a tick every cycle.
- Output register, on tick:
  - If sample_valid && ~sample_ready (downstream stalled): no pop, the tick is lost, and the held sample remains.
  - Else if FIFO not empty: pop, sample_data <= head, sample_valid <= 1.
  - Else (empty): sample_data <= 0 (silence), sample_valid <= 1, underrun set.
  - When there is no tick and sample_valid && sample_ready, sample_valid <= 0 next cycle.
  - sample_data is stable while sample_valid is high and not accepted.
- Interrupt:
  - lowflag = enable && (count <= THRESHOLD), registered into lowflag_d.
  - irq_pending sets on lowflag && ~lowflag_d, i.e. the rising edge only.
  - A STATUS write beats a simultaneous set.
  - irq = irq_pending && irq_enable, combinational from registers.
- CONTROL enable 1->0: the divider stops, FIFO contents are kept, and any pending output handshake still completes.

Test Plan:
- Reset, then read addrs 0..5 -> readdata one cycle later = 0x0004, 0, 0x0411, 0x0010, 0, 0; sample_valid=0, irq=0.
- DIVIDER=3, push 0x1111, 0x2222, CONTROL=0x1, sample_ready=1 -> sample_valid pulses every 4 cycles with 0x1111 then 0x2222. Third tick gives 0x0000 with STATUS bit3=1.
- Push 64 samples, then push 0xBEEF -> FILL=64, STATUS bits1 and 4 set, 0xBEEF never appears on sample_data. Write STATUS -> bit4 cleared.
- THRESHOLD=2, push 4 samples, CONTROL=0x3, DIVIDER=0, sample_ready=1 -> irq rises in the cycle after count drops 3->2 and stays high. Write STATUS -> irq low; it does not re-set while count stays ≤2.
- sample_ready=0 with DIVIDER=1 and 3 samples queued -> first sample held valid, FILL stays 2 across several ticks. Set sample_ready=1 -> the next samples follow in order with no loss from the FIFO.
- Same-cycle cases and resets: flush strobe while FIFO holds 10 samples -> FILL=0, STATUS bit2=1. Push on the same cycle as a pop -> FILL unchanged. Assert reset_n=0 mid-stream -> all outputs 0 asynchronously.
